sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, extra SRAM wait cycles per half-word access (range 0..7).
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 wr_en  input  1  pipeline MEM-stage write request.
REQ-005 rd_en  input  1  pipeline MEM-stage read request.
REQ-006 address  input  32  byte address from ALU result.
REQ-007 wdata  input  32  store data (Rm value).
REQ-008 rdata  output  32  load data, valid while ready=1 after a read.
REQ-009 ready  output  1  high = access complete or no request; low = freeze pipeline.
REQ-010 sram_addr  output  18  half-word address to external SRAM.
REQ-011 sram_dq_out  output  16  write data to SRAM.
REQ-012 sram_dq_oe  output  1  high = controller drives SRAM data bus.
REQ-013 sram_dq_in  input  16  read data from SRAM.
REQ-014 sram_we_n, sram_oe_n, sram_ce_n  output  1 each  active-low SRAM strobes.

Function
REQ-015 FSM states IDLE, LO, HI, DONE; one-hot or binary is an implementation choice.
REQ-016 IDLE: if wr_en|rd_en, latch address, wdata, op (write has priority when both high), go LO.
REQ-017 LO/HI: each held WAIT_CYCLES+1 cycles via down-counter, then advance LO->HI->DONE.
REQ-018 Address map: word = (address - 1024) >> 2; sram_addr = {word[16:0], half}, half=0 in LO, 1 in HI.
REQ-019 Read: sram_oe_n=0 in LO/HI; sram_dq_in sampled on last LO cycle into rdata[15:0], last HI cycle into rdata[31:16].
REQ-020 Write: sram_we_n=0, sram_dq_oe=1 in LO/HI; sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
REQ-021 sram_ce_n=0 only in LO/HI; all strobes high and sram_dq_oe=0 in IDLE/DONE.
REQ-022 ready = ~(wr_en|rd_en) in IDLE, 0 in LO/HI, 1 in DONE (combinational).
REQ-023 DONE lasts exactly one cycle, then IDLE unconditionally; IDLE re-evaluates request next cycle.
REQ-024 Latency: ready low for 2*WAIT_CYCLES+3 cycles, high in cycle 2*WAIT_CYCLES+4 after request assertion.
REQ-025 Request dropped mid-access: access completes; DONE still pulses ready.
REQ-026 rdata holds last read value until next read overwrites it; writes do not change rdata.
REQ-027 Address below 1024 or misaligned: no error; mapping per REQ-018 with wrap in 17 bits.

Reset
REQ-028 rst low: state=IDLE, counter=0, rdata=0, latched regs=0, strobes high, sram_dq_oe=0, sram_addr=0.
REQ-029 Reset mid-access aborts immediately; no partial write continues after rst deassertion.

Configuration
REQ-030 SRAM_CTRL_STATS_EN defined: outputs rd_count[15:0], wr_count[15:0], increment on DONE of respective op, saturate at 0xFFFF, reset to 0.
REQ-031 SRAM_CTRL_STATS_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-032 Shared package arm_mem_pkg: FSM state type, SRAM_BASE_ADDR=1024, SRAM_ADDR_W=18, SRAM_DATA_W=16.
REQ-033 One sub-module sram_wait_counter: loadable down-counter with zero flag, reused by LO and HI.

Verification
REQ-034 Read, WAIT_CYCLES=2, address=1028, SRAM[2]=0xBEEF, SRAM[3]=0x1234 -> ready low 7 cycles, then rdata=0x1234BEEF, ready=1 one cycle.
REQ-035 Write address=1024, wdata=0xCAFEF00D -> sram_addr 0 with 0xF00D, then 1 with 0xCAFE, we_n low 3 cycles each.
REQ-036 wr_en=rd_en=1 -> write performed, oe_n stays high, rdata unchanged.
REQ-037 Back-to-back read then write, request held until ready -> two DONE pulses, one IDLE cycle between.
REQ-038 rst asserted during HI of write -> strobes high same cycle, state IDLE, ready=~(wr_en|rd_en).
REQ-039 WAIT_CYCLES=0 read -> ready low 3 cycles, correct rdata; with SRAM_CTRL_STATS_EN rd_count=1.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM data-memory path to the external 16-bit SRAM.
// Also provides the byte-address to SRAM half-word address mapping helper.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
    localparam int          SRAM_ADDR_W    = 18;
    localparam int          SRAM_DATA_W    = 16;

    // Word index relative to the SRAM window, wrapped to 17 bits, with the half select as LSB.
    function automatic logic [SRAM_ADDR_W-1:0] sram_half_addr(
        input logic [31:0] byte_addr,
        input logic        half
    );
        logic [31:0] word;
        word = (byte_addr - SRAM_BASE_ADDR) >> 2'd2;
        return {word[SRAM_ADDR_W-2:0], half};
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with zero flag; paces how long each SRAM half-word phase is held.
module sram_wait_counter
    import arm_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       zero
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // Load takes priority; otherwise count down and stick at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 3'd0) begin
            count_d = count_q - 3'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == 3'd0);

endmodule

// File: rtl/sram_ctrl.sv
// Splits 32-bit pipeline loads/stores into two 16-bit SRAM accesses (low half, then high half).
// Optional build macro SRAM_CTRL_STATS_EN adds saturating rd_count/wr_count outputs.
module sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
`endif
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    sram_state_e            state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   is_wr_q, is_wr_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   ce_n_q, ce_n_d;
    logic                   cnt_load_s;
    logic                   cnt_zero_s;
    logic                   active_s;
    logic                   half_s;

    sram_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero_s)
    );

    // Next-state, request latching and read-data capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        rdata_d    = rdata_q;
        cnt_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_en || rd_en) begin
                    state_d    = ST_LO;
                    addr_d     = address;
                    wdata_d    = wdata;
                    is_wr_d    = wr_en;
                    cnt_load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO: begin
                if (cnt_zero_s) begin
                    state_d    = ST_HI;
                    cnt_load_s = 1'b1;
                    if (!is_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_LO;
                end
            end
            ST_HI: begin
                if (cnt_zero_s) begin
                    state_d = ST_DONE;
                    if (!is_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // SRAM pins are registered, so decode them from the state being entered.
    always_comb begin
        active_s    = (state_d == ST_LO) || (state_d == ST_HI);
        half_s      = (state_d == ST_HI);
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        if (active_s) begin
            sram_addr_d = sram_half_addr(addr_d, half_s);
            if (is_wr_d) begin
                dq_out_d = half_s ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                dq_out_d = dq_out_q;
            end
        end else begin
            sram_addr_d = sram_addr_q;
        end
        ce_n_d  = ~active_s;
        we_n_d  = ~(active_s & is_wr_d);
        oe_n_d  = ~(active_s & ~is_wr_d);
        dq_oe_d = active_s & is_wr_d;
    end

    // State, latched request and SRAM pin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            is_wr_q     <= 1'b0;
            rdata_q     <= 32'd0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            ce_n_q      <= ce_n_d;
        end
    end

    // The pipeline stalls combinationally on a fresh request seen in IDLE.
    assign ready       = (state_q == ST_IDLE) ? ~(wr_en | rd_en) : (state_q == ST_DONE);
    assign rdata       = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_ce_n   = ce_n_q;

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Saturating completion counters, bumped once per DONE.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == ST_DONE) begin
            if (is_wr_q) begin
                wr_count_d = (wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
            end else begin
                rd_count_d = (rd_count_q != 16'hFFFF) ? rd_count_q + 16'd1 : rd_count_q;
            end
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: default WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance,
// each backed by a behavioural 16-bit SRAM; read data and SRAM write cycles are scoreboarded.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, wdata;

    logic [31:0] rdata, rdata0;
    logic        ready, ready0;
    logic [17:0] sram_addr, sram_addr0;
    logic [15:0] dq_out, dq_out0, dq_in, dq_in0;
    logic        dq_oe, dq_oe0, we_n, we_n0, oe_n, oe_n0, ce_n, ce_n0;
`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_count, wr_count, rd_count0, wr_count0;
`endif

    logic [15:0] mem  [0:262143];
    logic [15:0] mem0 [0:262143];

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_rd_q[$];
    logic [33:0] exp_wr_q[$];
    logic [33:0] wr_log[$];
    int          oe_low_cnt = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address), .wdata(wdata),
        .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_out(dq_out),
        .sram_dq_oe(dq_oe), .sram_dq_in(dq_in), .sram_we_n(we_n), .sram_oe_n(oe_n), .sram_ce_n(ce_n)
`ifdef SRAM_CTRL_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    sram_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .sram_addr(sram_addr0), .sram_dq_out(dq_out0),
        .sram_dq_oe(dq_oe0), .sram_dq_in(dq_in0), .sram_we_n(we_n0), .sram_oe_n(oe_n0), .sram_ce_n(ce_n0)
`ifdef SRAM_CTRL_STATS_EN
        , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
    );

    assign dq_in  = mem[sram_addr];
    assign dq_in0 = mem0[sram_addr0];

    // Behavioural SRAMs: write on the clock edge while selected and write-enabled.
    always @(posedge clk) begin
        if (!we_n && !ce_n) mem[sram_addr] <= dq_out;
        if (!we_n0 && !ce_n0) mem0[sram_addr0] <= dq_out0;
    end

    // Bus monitor for the main instance: log every write cycle and count output-enable cycles.
    always @(negedge clk) begin
        if (!we_n && !ce_n) wr_log.push_back({sram_addr, dq_out});
        if (!oe_n) oe_low_cnt <= oe_low_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run_access(input bit sel0, input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, input bit hold, output int low_cycles);
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = a; wdata = d;
        low_cycles = 0;
        #1;
        while ((sel0 ? ready0 : ready) !== 1'b1 && low_cycles < 200) begin
            low_cycles++;
            @(negedge clk);
            #1;
        end
        if (!hold) begin
            wr_en = 1'b0; rd_en = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] got;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        got = {ready, we_n, oe_n, ce_n, dq_oe, 27'd0};
        total++;
        if (got !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 27'd0}) $display("FAIL reset_strobes: got %h expected %h", got, {5'b11110, 27'd0});
        else passed++;
        total++;
        if (sram_addr !== 18'd0) $display("FAIL reset_addr: got %h expected 0", sram_addr);
        else passed++;
        total++;
        if (rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", rdata);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_write();
        int low; int base;
        base = wr_log.size();
        for (int i = 0; i < 3; i++) exp_wr_q.push_back({18'd0, 16'hF00D});
        for (int i = 0; i < 3; i++) exp_wr_q.push_back({18'd1, 16'hCAFE});
        run_access(1'b0, 1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 1'b0, low);
        total++;
        if (low !== 7) $display("FAIL write_latency: got %0d expected 7", low);
        else passed++;
        idle(2);
        total++;
        if (wr_log.size() - base !== 6) $display("FAIL write_cycles: got %0d expected 6", wr_log.size() - base);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            logic [33:0] e;
            e = exp_wr_q.pop_front();
            total++;
            if (base + i >= wr_log.size() || wr_log[base + i] !== e)
                $display("FAIL write_bus[%0d]: got %h expected %h", i,
                         (base + i < wr_log.size()) ? wr_log[base + i] : 34'h0, e);
            else passed++;
        end
        idle(6);
    endtask

    task automatic test_read();
        int low;
        run_access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h1234BEEF, 1'b0, low);
        idle(8);
        exp_rd_q.push_back(32'h1234BEEF);
        run_access(1'b0, 1'b0, 1'b1, 32'd1028, 32'd0, 1'b1, low);
        total++;
        if (low !== 7) $display("FAIL read_latency: got %0d expected 7", low);
        else passed++;
        total++;
        if (rdata !== exp_rd_q[0]) $display("FAIL read_data: got %h expected %h", rdata, exp_rd_q[0]);
        else passed++;
        void'(exp_rd_q.pop_front());
        @(negedge clk);
        #1;
        total++;
        if (ready !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", ready);
        else passed++;
        idle(10);
    endtask

    task automatic test_priority();
        int low; int base; int oe_base;
        base = wr_log.size();
        oe_base = oe_low_cnt;
        run_access(1'b0, 1'b1, 1'b1, 32'd1032, 32'h55AA33CC, 1'b0, low);
        total++;
        if (low !== 7) $display("FAIL prio_latency: got %0d expected 7", low);
        else passed++;
        total++;
        if (rdata !== 32'h1234BEEF) $display("FAIL prio_rdata_kept: got %h expected 1234beef", rdata);
        else passed++;
        idle(2);
        total++;
        if (oe_low_cnt !== oe_base) $display("FAIL prio_oe_n: got %0d oe cycles expected 0", oe_low_cnt - oe_base);
        else passed++;
        total++;
        if (wr_log.size() - base !== 6 || wr_log[base] !== {18'd4, 16'h33CC} || wr_log[base + 3] !== {18'd5, 16'h55AA})
            $display("FAIL prio_write: got %0d cycles expected 6 to addr 4/5", wr_log.size() - base);
        else passed++;
        idle(6);
        exp_rd_q.push_back(32'h55AA33CC);
        run_access(1'b0, 1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, low);
        total++;
        if (rdata !== exp_rd_q[0]) $display("FAIL prio_readback: got %h expected %h", rdata, exp_rd_q[0]);
        else passed++;
        void'(exp_rd_q.pop_front());
        idle(10);
    endtask

    task automatic test_wrap();
        int low; int base;
        base = wr_log.size();
        run_access(1'b0, 1'b1, 1'b0, 32'd0, 32'hDEAD0001, 1'b0, low);
        idle(2);
        total++;
        if (wr_log.size() <= base || wr_log[base] !== {18'h3FE00, 16'h0001})
            $display("FAIL wrap_addr: got %h expected %h", (wr_log.size() > base) ? wr_log[base] : 34'h0, {18'h3FE00, 16'h0001});
        else passed++;
        idle(6);
        exp_rd_q.push_back(32'hDEAD0001);
        exp_rd_q.push_back(32'h1234BEEF);
        run_access(1'b0, 1'b0, 1'b1, 32'd3, 32'd0, 1'b0, low);
        total++;
        if (rdata !== exp_rd_q[0]) $display("FAIL wrap_read: got %h expected %h", rdata, exp_rd_q[0]);
        else passed++;
        void'(exp_rd_q.pop_front());
        idle(10);
        run_access(1'b0, 1'b0, 1'b1, 32'd1031, 32'd0, 1'b0, low);
        total++;
        if (rdata !== exp_rd_q[0]) $display("FAIL misaligned_read: got %h expected %h", rdata, exp_rd_q[0]);
        else passed++;
        void'(exp_rd_q.pop_front());
        idle(10);
    endtask

    task automatic test_back_to_back();
        int low;
        exp_rd_q.push_back(32'h1234BEEF);
        run_access(1'b0, 1'b0, 1'b1, 32'd1028, 32'd0, 1'b1, low);
        total++;
        if (rdata !== exp_rd_q[0] || low !== 7) $display("FAIL b2b_read: got %h/%0d expected %h/7", rdata, low, exp_rd_q[0]);
        else passed++;
        void'(exp_rd_q.pop_front());
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1056; wdata = 32'h0BADCAFE;
        @(negedge clk);
        #1;
        total++;
        if (ready !== 1'b0 || ce_n !== 1'b1) $display("FAIL b2b_idle_gap: got ready=%b ce_n=%b expected 0/1", ready, ce_n);
        else passed++;
        low = 1;
        @(negedge clk);
        #1;
        total++;
        if (ce_n !== 1'b0 || we_n !== 1'b0) $display("FAIL b2b_write_start: got ce_n=%b we_n=%b expected 0/0", ce_n, we_n);
        else passed++;
        while (ready !== 1'b1 && low < 200) begin
            low++;
            @(negedge clk);
            #1;
        end
        total++;
        if (low !== 7) $display("FAIL b2b_second_done: got %0d low cycles expected 7", low);
        else passed++;
        idle(8);
        exp_rd_q.push_back(32'h0BADCAFE);
        run_access(1'b0, 1'b0, 1'b1, 32'd1056, 32'd0, 1'b0, low);
        total++;
        if (rdata !== exp_rd_q[0]) $display("FAIL b2b_readback: got %h expected %h", rdata, exp_rd_q[0]);
        else passed++;
        void'(exp_rd_q.pop_front());
        idle(10);
    endtask

    task automatic test_reset_mid();
        int n;
        int ce_high;
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1040; wdata = 32'hAAAA5555;
        n = 0;
        #1;
        while (!(ce_n === 1'b0 && sram_addr === 18'd9) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 100) $display("FAIL rstmid_reach_hi: got timeout expected HI phase");
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if ({we_n, oe_n, ce_n, dq_oe, ready} !== 5'b11100) $display("FAIL rstmid_strobes: got %b expected 11100", {we_n, oe_n, ce_n, dq_oe, ready});
        else passed++;
        total++;
        if (rdata !== 32'd0) $display("FAIL rstmid_rdata: got %h expected 0", rdata);
        else passed++;
        @(negedge clk);
        wr_en = 1'b0;
        rst = 1'b1;
        ce_high = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (ce_n === 1'b1 && we_n === 1'b1 && ready === 1'b1) ce_high++;
        end
        total++;
        if (ce_high !== 5) $display("FAIL rstmid_no_resume: got %0d idle cycles expected 5", ce_high);
        else passed++;
    endtask

    task automatic test_w0();
        int low;
        run_access(1'b1, 1'b1, 1'b0, 32'd1028, 32'h9ABC5678, 1'b0, low);
        total++;
        if (low !== 3) $display("FAIL w0_write_latency: got %0d expected 3", low);
        else passed++;
        idle(10);
        exp_rd_q.push_back(32'h9ABC5678);
        run_access(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, low);
        total++;
        if (low !== 3) $display("FAIL w0_read_latency: got %0d expected 3", low);
        else passed++;
        total++;
        if (rdata0 !== exp_rd_q[0]) $display("FAIL w0_read_data: got %h expected %h", rdata0, exp_rd_q[0]);
        else passed++;
        void'(exp_rd_q.pop_front());
        idle(3);
`ifdef SRAM_CTRL_STATS_EN
        total++;
        if (rd_count0 !== 16'd1 || wr_count0 !== 16'd1) $display("FAIL w0_stats: got rd=%0d wr=%0d expected 1/1", rd_count0, wr_count0);
        else passed++;
`endif
        idle(10);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_priority();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_w0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
